// File: rtl/apb2ram_pkg.sv
// Shared types and defaults for the APB3-to-RAM bridge.
package apb2ram_pkg;

  typedef enum logic [1:0] {StIdle, StWr, StRdWait, StResp} state_e;

  localparam int unsigned MaxDwordDefault = 32'h0000_000F;
  // Wide enough to count the largest supported read latency (7).
  localparam int unsigned RdLatCntW       = 3;

endpackage

// File: rtl/apb2ram_bridge.sv
// APB3 slave to single-port RAM bus bridge; every output is registered.
// Optional address range check and error counter: APB2RAM_ADDR_CHECK_EN.
module apb2ram_bridge
  import apb2ram_pkg::*;
#(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned MAX_DWORD = MaxDwordDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W+1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  output logic [DATA_W-1:0] prdata,
  output logic              pready,
  output logic              pslverr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_datain,
  output logic              ram_enable,
  input  logic [DATA_W-1:0] ram_dataout,
  output logic              busy
`ifdef APB2RAM_ADDR_CHECK_EN
  ,
  output logic [7:0]        err_cnt
`endif
);

  localparam logic [ADDR_W-1:0]    MaxAddr   = ADDR_W'(MAX_DWORD);
  localparam logic [RdLatCntW-1:0] RdLatLast = RdLatCntW'(RD_LAT);

  state_e                state_q, state_d;
  logic [RdLatCntW-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]     prdata_d, ram_datain_d;
  logic [ADDR_W-1:0]     ram_addr_d, req_addr;
  logic                  pready_d, ram_we_d, ram_enable_d, busy_d;

  // Byte offset bits are don't-care on a dword-addressed RAM.
  assign req_addr = paddr[ADDR_W+1:2];
  logic unused_lsb;
  assign unused_lsb = ^paddr[1:0];

`ifdef APB2RAM_ADDR_CHECK_EN
  logic       pslverr_d;
  logic [7:0] err_cnt_d;
`else
  assign pslverr = 1'b0;
  logic unused_max;
  assign unused_max = ^MaxAddr;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    prdata_d     = prdata;
    pready_d     = 1'b0;
    ram_addr_d   = ram_addr;
    ram_datain_d = ram_datain;
    ram_we_d     = 1'b0;
    ram_enable_d = 1'b0;
`ifdef APB2RAM_ADDR_CHECK_EN
    pslverr_d    = 1'b0;
    err_cnt_d    = err_cnt;
`endif
    unique case (state_q)
      StIdle: begin
        if (psel && penable) begin
`ifdef APB2RAM_ADDR_CHECK_EN
          if (req_addr > MaxAddr) begin
            state_d   = StResp;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = '0;
            if (err_cnt != 8'hFF) err_cnt_d = err_cnt + 8'd1;
          end else
`endif
          begin
            ram_addr_d   = req_addr;
            ram_enable_d = 1'b1;
            if (pwrite) begin
              ram_we_d     = 1'b1;
              ram_datain_d = pwdata;
              state_d      = StWr;
            end else begin
              cnt_d   = '0;
              state_d = StRdWait;
            end
          end
        end
      end
      StWr: begin
        pready_d = 1'b1;
        state_d  = StResp;
      end
      StRdWait: begin
        // First cycle here is the strobe cycle; data lands RD_LAT cycles later.
        if (cnt_q == RdLatLast) begin
          prdata_d = ram_dataout;
          pready_d = 1'b1;
          state_d  = StResp;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      prdata     <= '0;
      pready     <= 1'b0;
      ram_addr   <= '0;
      ram_datain <= '0;
      ram_we     <= 1'b0;
      ram_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prdata     <= prdata_d;
      pready     <= pready_d;
      ram_addr   <= ram_addr_d;
      ram_datain <= ram_datain_d;
      ram_we     <= ram_we_d;
      ram_enable <= ram_enable_d;
      busy       <= busy_d;
    end
  end

`ifdef APB2RAM_ADDR_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pslverr <= 1'b0;
      err_cnt <= '0;
    end else begin
      pslverr <= pslverr_d;
      err_cnt <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_apb2ram_bridge.sv
// Bench for apb2ram_bridge: RD_LAT=1 instance with a register-file slave and an
// RD_LAT=3 instance with scripted ram_dataout; APB2RAM_ADDR_CHECK_EN aware.
`timescale 1ns/1ps
module tb_apb2ram_bridge;

  localparam int AW = 16;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          psel = 1'b0, penable = 1'b0, pwrite = 1'b0, sel3 = 1'b0;
  logic [AW+1:0] paddr = '0;
  logic [DW-1:0] pwdata = '0;
  logic          psel1, penable1, psel3, penable3;
  assign psel1    = psel & ~sel3;
  assign penable1 = penable & ~sel3;
  assign psel3    = psel & sel3;
  assign penable3 = penable & sel3;

  logic [DW-1:0] prdata1, ram_datain1, ram_dataout1, prdata3, ram_datain3, ram_dataout3;
  logic [AW-1:0] ram_addr1, ram_addr3;
  logic          pready1, pslverr1, ram_we1, ram_enable1, busy1;
  logic          pready3, pslverr3, ram_we3, ram_enable3, busy3;
  logic [7:0]    err_cnt1, err_cnt3;

  apb2ram_bridge #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .MAX_DWORD(16'h000F)) dut1 (
    .clk(clk), .rst_n(rst_n), .psel(psel1), .penable(penable1), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata1), .pready(pready1), .pslverr(pslverr1),
    .ram_addr(ram_addr1), .ram_we(ram_we1), .ram_datain(ram_datain1),
    .ram_enable(ram_enable1), .ram_dataout(ram_dataout1), .busy(busy1)
`ifdef APB2RAM_ADDR_CHECK_EN
    , .err_cnt(err_cnt1)
`endif
  );

  apb2ram_bridge #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3), .MAX_DWORD(16'h000F)) dut3 (
    .clk(clk), .rst_n(rst_n), .psel(psel3), .penable(penable3), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
    .ram_addr(ram_addr3), .ram_we(ram_we3), .ram_datain(ram_datain3),
    .ram_enable(ram_enable3), .ram_dataout(ram_dataout3), .busy(busy3)
`ifdef APB2RAM_ADDR_CHECK_EN
    , .err_cnt(err_cnt3)
`endif
  );

`ifndef APB2RAM_ADDR_CHECK_EN
  assign err_cnt1 = '0;
  assign err_cnt3 = '0;
`endif

  // Register-file slave for dut1: one-cycle registered read.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rdout1 = '0;
  always @(posedge clk)
    if (ram_enable1) begin
      if (ram_we1) mem[ram_addr1[7:0]] <= ram_datain1;
      else         rdout1 <= mem[ram_addr1[7:0]];
    end
  assign ram_dataout1 = rdout1;

  // dut3 data: only the cycle three cycles after its strobe carries good3.
  logic [3:0]    ph = '0;
  logic [DW-1:0] good3 = '0;
  always @(posedge clk)
    if (ram_enable3) ph <= 4'd1;
    else if (ph != 4'd0) ph <= ph + 4'd1;
  assign ram_dataout3 = (ph == 4'd3) ? good3 : {28'hBAD0000, ph};

  // Muxed view of the addressed instance.
  logic          x_pready, x_pslverr, x_en, x_we;
  logic [DW-1:0] x_prdata, x_din;
  logic [AW-1:0] x_addr;
  assign x_pready  = sel3 ? pready3 : pready1;
  assign x_pslverr = sel3 ? pslverr3 : pslverr1;
  assign x_en      = sel3 ? ram_enable3 : ram_enable1;
  assign x_we      = sel3 ? ram_we3 : ram_we1;
  assign x_prdata  = sel3 ? prdata3 : prdata1;
  assign x_din     = sel3 ? ram_datain3 : ram_datain1;
  assign x_addr    = sel3 ? ram_addr3 : ram_addr1;

  // Reference model.
  logic [DW-1:0] exp_mem [256];
  bit            exp_valid [256];
  int            err_exp = 0;

  int n_chk = 0, n_pass = 0;

  // Results of the last transfer; k counts cycles after the accepting edge T.
  logic [DW-1:0] r_data, r_din;
  logic [AW-1:0] r_addr;
  logic          r_err;
  int            r_k, r_en, r_enk, r_we, r_wek;

  task automatic apb_xfer(input bit tgt, input bit wr, input logic [AW+1:0] a,
                          input logic [DW-1:0] d);
    r_k = -1; r_en = 0; r_enk = -1; r_we = 0; r_wek = -1;
    r_data = '0; r_err = 1'b0; r_addr = '0; r_din = '0;
    @(negedge clk);
    sel3 = tgt; psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20 && r_k < 0; k++) begin
      @(negedge clk);
      if (x_en) begin r_en++; r_enk = k; r_addr = x_addr; r_din = x_din; end
      if (x_we) begin r_we++; r_wek = k; end
      if (x_pready) begin r_k = k; r_data = x_prdata; r_err = x_pslverr; end
    end
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    n_chk++;
    if ({prdata1, pready1, pslverr1, ram_addr1, ram_we1, ram_datain1, ram_enable1, busy1,
         err_cnt1} !== '0) $display("FAIL reset_outputs: got nonzero output after reset, need all 0");
    else n_pass++;
    n_chk++;
    if ({prdata3, pready3, ram_enable3, busy3} !== '0)
      $display("FAIL reset_outputs_lat3: got nonzero output, need all 0");
    else n_pass++;
  endtask

  task automatic test_write();
    apb_xfer(1'b0, 1'b1, 18'h24, 32'hDEADBEEF);
    exp_mem[9] = 32'hDEADBEEF; exp_valid[9] = 1'b1;
    n_chk++;
    if (r_addr !== 16'h0009 || r_din !== 32'hDEADBEEF)
      $display("FAIL write_bus: got addr %h data %h, need 0009 deadbeef", r_addr, r_din);
    else n_pass++;
    n_chk++;
    if (r_en !== 1 || r_enk !== 1 || r_we !== 1 || r_wek !== 1)
      $display("FAIL write_strobe: got en %0d@%0d we %0d@%0d, need 1@1 1@1", r_en, r_enk, r_we, r_wek);
    else n_pass++;
    n_chk++;
    if (r_k !== 2 || r_err !== 1'b0)
      $display("FAIL write_ready: got pready at T+%0d err %b, need T+2 err 0", r_k, r_err);
    else n_pass++;
  endtask

  task automatic test_read();
    apb_xfer(1'b0, 1'b0, 18'h24, '0);
    n_chk++;
    if (r_en !== 1 || r_enk !== 1 || r_we !== 0)
      $display("FAIL read_strobe: got en %0d@%0d we %0d, need 1@1 we 0", r_en, r_enk, r_we);
    else n_pass++;
    n_chk++;
    if (r_k !== 3 || r_data !== exp_mem[9])
      $display("FAIL read_data: got T+%0d %h, need T+3 %h", r_k, r_data, exp_mem[9]);
    else n_pass++;
  endtask

  task automatic test_illegal();
`ifdef APB2RAM_ADDR_CHECK_EN
    apb_xfer(1'b0, 1'b0, 18'h40, '0);
    err_exp = 1;
    n_chk++;
    if (r_k !== 1 || r_err !== 1'b1 || r_en !== 0 || r_data !== '0)
      $display("FAIL illegal_resp: got T+%0d err %b en %0d data %h, need T+1 1 0 0",
               r_k, r_err, r_en, r_data);
    else n_pass++;
    n_chk++;
    if (err_cnt1 !== 8'd1) $display("FAIL illegal_cnt: got %0d, need 1", err_cnt1);
    else n_pass++;
`else
    apb_xfer(1'b0, 1'b1, 18'h40, 32'h0BAD_F00D);
    exp_mem[16] = 32'h0BAD_F00D; exp_valid[16] = 1'b1;
    apb_xfer(1'b0, 1'b0, 18'h40, '0);
    n_chk++;
    if (r_addr !== 16'h0010 || r_en !== 1 || r_err !== 1'b0 || r_k !== 3)
      $display("FAIL forward_addr: got addr %h en %0d err %b T+%0d, need 0010 1 0 T+3",
               r_addr, r_en, r_err, r_k);
    else n_pass++;
    n_chk++;
    if (r_data !== exp_mem[16]) $display("FAIL forward_data: got %h, need %h", r_data, exp_mem[16]);
    else n_pass++;
`endif
  endtask

  task automatic test_rdlat3();
    for (int i = 0; i < 2; i++) begin
      good3 = $urandom;
      apb_xfer(1'b1, 1'b0, 18'(($urandom_range(0, 15) << 2)), '0);
      n_chk++;
      if (r_k !== 5 || r_en !== 1 || r_enk !== 1)
        $display("FAIL lat3_timing: got pready T+%0d en %0d@%0d, need T+5 1@1", r_k, r_en, r_enk);
      else n_pass++;
      n_chk++;
      if (r_data !== good3) $display("FAIL lat3_capture: got %h, need %h", r_data, good3);
      else n_pass++;
    end
    sel3 = 1'b0;
  endtask

  task automatic test_reset_mid();
    int rdy = 0;
    @(negedge clk);
    sel3 = 1'b0; psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 18'h24;
    @(negedge clk);
    penable = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (busy1 !== 1'b1 || ram_enable1 !== 1'b1)
      $display("FAIL midrst_pre: got busy %b en %b, need 1 1", busy1, ram_enable1);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({prdata1, pready1, pslverr1, ram_addr1, ram_we1, ram_datain1, ram_enable1, busy1,
         err_cnt1} !== '0) $display("FAIL midrst_async: got nonzero output in reset, need all 0");
    else n_pass++;
    psel = 1'b0; penable = 1'b0; err_exp = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (pready1) rdy++;
    end
    n_chk++;
    if (rdy !== 0) $display("FAIL midrst_noready: got %0d pready cycles, need 0", rdy);
    else n_pass++;
    apb_xfer(1'b0, 1'b0, 18'h24, '0);
    n_chk++;
    if (r_k !== 3 || r_data !== exp_mem[9])
      $display("FAIL midrst_after: got T+%0d %h, need T+3 %h", r_k, r_data, exp_mem[9]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d0, d2, rd;
    int done = 0, en = 0, rdy = 0, low = 0;
    bit started = 1'b0;
    d0 = $urandom; d2 = $urandom; rd = '0;
    @(negedge clk);
    sel3 = 1'b0; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 18'h0C; pwdata = d0;
    for (int c = 0; c < 40 && done < 3; c++) begin
      @(negedge clk);
      if (ram_enable1) en++;
      if (busy1) started = 1'b1;
      else if (started) low++;
      if (pready1) begin
        rdy++; done++;
        if (done == 1) pwrite = 1'b0;
        if (done == 2) begin rd = prdata1; pwrite = 1'b1; paddr = 18'h14; pwdata = d2; end
      end
    end
    psel = 1'b0; penable = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (ram_enable1) en++;
      if (pready1) rdy++;
    end
    exp_mem[3] = d0; exp_valid[3] = 1'b1;
    exp_mem[5] = d2; exp_valid[5] = 1'b1;
    n_chk++;
    if (en !== 3 || rdy !== 3)
      $display("FAIL b2b_pulses: got en %0d pready %0d, need 3 3", en, rdy);
    else n_pass++;
    n_chk++;
    if (low !== 2) $display("FAIL b2b_busy: got %0d idle cycles between, need 2", low);
    else n_pass++;
    n_chk++;
    if (rd !== d0) $display("FAIL b2b_read: got %h, need %h", rd, d0);
    else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      int            dw;
      bit            wr, bad;
      logic [DW-1:0] d;
      logic [AW+1:0] a;
      dw = int'($urandom_range(0, 63));
      wr = 1'($urandom_range(0, 1));
      d  = $urandom;
      a  = (18'(dw) << 2) | 18'($urandom_range(0, 3));
`ifdef APB2RAM_ADDR_CHECK_EN
      bad = (dw > 15);
`else
      bad = 1'b0;
`endif
      if (!bad && !exp_valid[dw]) wr = 1'b1;
      apb_xfer(1'b0, wr, a, d);
      n_chk++;
      if (bad) begin
        err_exp = (err_exp < 255) ? err_exp + 1 : 255;
        if (r_k !== 1 || r_err !== 1'b1 || r_en !== 0 || r_data !== '0 || int'(err_cnt1) !== err_exp)
          $display("FAIL rand_illegal: got T+%0d err %b en %0d data %h cnt %0d, need T+1 1 0 0 %0d",
                   r_k, r_err, r_en, r_data, err_cnt1, err_exp);
        else n_pass++;
      end else if (wr) begin
        if (r_k !== 2 || r_en !== 1 || r_we !== 1 || r_err !== 1'b0 || r_addr !== AW'(dw) || r_din !== d)
          $display("FAIL rand_write: got T+%0d en %0d we %0d addr %h din %h, need T+2 1 1 %h %h",
                   r_k, r_en, r_we, r_addr, r_din, AW'(dw), d);
        else n_pass++;
        exp_mem[dw] = d; exp_valid[dw] = 1'b1;
      end else begin
        if (r_k !== 3 || r_en !== 1 || r_we !== 0 || r_err !== 1'b0 || r_data !== exp_mem[dw])
          $display("FAIL rand_read: got T+%0d en %0d we %0d data %h, need T+3 1 0 %h",
                   r_k, r_en, r_we, r_data, exp_mem[dw]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_err_saturate();
`ifdef APB2RAM_ADDR_CHECK_EN
    for (int i = 0; i < 300; i++) begin
      apb_xfer(1'b0, 1'($urandom_range(0, 1)), 18'h40, '0);
      err_exp = (err_exp < 255) ? err_exp + 1 : 255;
    end
    n_chk++;
    if (int'(err_cnt1) !== err_exp || err_cnt1 !== 8'd255)
      $display("FAIL err_saturate: got %0d, need 255", err_cnt1);
    else n_pass++;
`endif
  endtask

  initial begin
    for (int i = 0; i < 256; i++) exp_valid[i] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_illegal();
    test_rdlat3();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_err_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/apb2ram_bridge.md
APB2RAM_BRIDGE -- requirements
Module: apb2ram_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, 16: ram bus dword-address width.
REQ-002 SHALL have parameter DATA_W, 32: data width.
REQ-003 SHALL have parameter RD_LAT, 1: cycles from ram_enable to valid ram_dataout (1..7).
REQ-004 SHALL have parameter MAX_DWORD, 16'h000F: highest legal dword address.
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-007 SHALL have APB3 slave ports psel, penable, pwrite (inputs, 1); paddr (input, ADDR_W+2, byte address); pwdata (input, DATA_W).
REQ-008 SHALL have APB3 slave outputs prdata (DATA_W), pready (1), pslverr (1).
REQ-009 SHALL have ram-bus master outputs ram_addr (ADDR_W), ram_we (1), ram_datain (DATA_W), ram_enable (1).
REQ-010 SHALL have ram-bus input ram_dataout (DATA_W), registered by the downstream register file.
REQ-011 SHALL have output busy (1): state is not IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, WR, RD_WAIT, RESP.
REQ-013 SHALL, in IDLE, accept a transfer on psel&&penable sampled at edge T; ram_addr = paddr[ADDR_W+1:2]; paddr[1:0] ignored.
REQ-014 SHALL, for writes, drive ram_enable=ram_we=1 with ram_addr/ram_datain=pwdata for exactly cycle T+1 (state WR), then RESP.
REQ-015 SHALL, for reads, drive ram_enable=1, ram_we=0 for exactly cycle T+1, then count RD_LAT cycles in RD_WAIT and capture ram_dataout into prdata at the end of cycle T+1+RD_LAT.
REQ-016 SHALL, in RESP, assert pready for exactly one cycle (write: T+2; read: T+2+RD_LAT), then return to IDLE.
REQ-017 SHALL hold ram_addr/ram_datain stable, not assert ram_we without ram_enable, and assert ram_enable exactly one cycle per accepted transfer.
REQ-018 SHALL drive all outputs from flops; no combinational path from APB inputs to any output.
REQ-019 SHALL ignore psel/penable outside IDLE; a transfer in progress completes even if psel drops early (no abort).
REQ-020 SHALL keep prdata at its last value except when loaded by a read or cleared on error.
REQ-021 SHALL accept back-to-back transfers: new psel&&penable sampled in the cycle after RESP starts the next transfer.

Reset
REQ-022 SHALL, on rst_n low, immediately force IDLE, prdata=0, pready=0, pslverr=0, ram_addr=0, ram_we=0, ram_datain=0, ram_enable=0, busy=0, err_cnt=0, even mid-transfer.
REQ-023 SHALL NOT issue pready for a transfer interrupted by reset.

Configuration
REQ-024 SHALL, with APB2RAM_ADDR_CHECK_EN defined, treat ram_addr > MAX_DWORD as illegal: no ram strobe, RESP at T+1 with pready=pslverr=1, prdata=0.
REQ-025 SHALL, with APB2RAM_ADDR_CHECK_EN defined, provide output err_cnt (8 bits), incremented per illegal access, saturating at 255.
REQ-026 SHALL, without APB2RAM_ADDR_CHECK_EN, forward every address, tie pslverr to 0, and omit err_cnt.

Structure
REQ-027 SHALL take FSM state enum, default MAX_DWORD and RD_LAT counter width from shared package apb2ram_pkg.
REQ-028 SHALL be a single module; no sub-module.

Verification
REQ-029 SHALL check: write paddr 0x24 data 0xDEADBEEF at T -> ram_addr=0x0009, ram_we=ram_enable=1 only at T+1, pready at T+2, pslverr=0.
REQ-030 SHALL check: read paddr 0x24 after that write, RD_LAT=1, reg file attached -> ram_enable at T+1, prdata=0xDEADBEEF with pready at T+3.
REQ-031 SHALL check: with macro, read paddr 0x40 -> no ram_enable, pready=pslverr=1 at T+1, prdata=0, err_cnt=1; 300 such accesses -> err_cnt=255.
REQ-032 SHALL check: RD_LAT=3 read -> pready at T+5; ram_dataout changing before T+4 not captured.
REQ-033 SHALL check: rst_n low during RD_WAIT -> all outputs 0 asynchronously, no pready; next read after reset completes normally.
REQ-034 SHALL check: back-to-back write/read/write with psel held -> one ram_enable pulse each, three pready pulses, busy low only between transfers.
